regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated destination scoreboard, the next-generation replacement for the CPU datapath's fixed 32×32, two-read-port register file. It provides NRD combinational read ports and one clocked write port. It tracks which registers have an issued-but-not-written-back producer, so the issue stage can stall on RAW/WAW hazards. It sits between decode/issue (read, issue-marking) and writeback (write, busy clear).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 80 ++++++++
 rtl/regfile_sb.sv | 96 +++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and packed-port helpers for the regfile_sb register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_NREGS  = 32;
  localparam int REGFILE_NRD    = 2;

  // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Destination scoreboard: busy vector, busy count and issue acceptance.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS   = REGFILE_NREGS,
  parameter int AW      = $clog2(NREGS),
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  output logic             issue_ready,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] busy_r;
  logic [AW:0]      busy_cnt_r;
  logic [NREGS-1:0] busy_next_s;
  logic [AW:0]      cnt_next_s;
  logic             issue_ready_s;
  logic             clr_s;
  logic             set_s;

  // Ready reflects committed state only; r0 is always accepted when hard-wired.
  always_comb begin
    issue_ready_s = 1'b1;
    if (ZERO_R0 && (issue_addr == {AW{1'b0}})) begin
      issue_ready_s = 1'b1;
    end else begin
      issue_ready_s = !busy_r[issue_addr];
    end
  end

  // Next busy vector and count; a same-address write+issue nets to busy.
  always_comb begin
    busy_next_s = busy_r;
    cnt_next_s  = busy_cnt_r;
    clr_s       = 1'b0;
    set_s       = 1'b0;
    if (we && !(ZERO_R0 && (wr_addr == {AW{1'b0}}))) begin
      clr_s                = busy_r[wr_addr];
      busy_next_s[wr_addr] = 1'b0;
    end else begin
      clr_s = 1'b0;
    end
    if (issue_valid && issue_ready_s && !(ZERO_R0 && (issue_addr == {AW{1'b0}}))) begin
      set_s                   = 1'b1;
      busy_next_s[issue_addr] = 1'b1;
    end else begin
      set_s = 1'b0;
    end
    if (set_s && !clr_s) begin
      cnt_next_s = busy_cnt_r + {{AW{1'b0}}, 1'b1};
    end else if (clr_s && !set_s) begin
      cnt_next_s = busy_cnt_r - {{AW{1'b0}}, 1'b1};
    end else begin
      cnt_next_s = busy_cnt_r;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= {NREGS{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      busy_r     <= busy_next_s;
      busy_cnt_r <= cnt_next_s;
    end
  end

  assign issue_ready = issue_ready_s;
  assign busy        = busy_r;
  assign busy_cnt    = busy_cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with destination scoreboard.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = REGFILE_DATA_W,
  parameter int NREGS   = REGFILE_NREGS,
  parameter int AW      = $clog2(NREGS),
  parameter int NRD     = REGFILE_NRD,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  output logic                  issue_ready,
  output logic [AW:0]           busy_cnt
);

  logic [DATA_W-1:0] mem_r [NREGS];
  logic [NREGS-1:0]  busy_s;
  logic [AW-1:0]     rd_addr_s [NRD];
  logic              wr_en_s;

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .wr_addr     (wr_addr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .busy        (busy_s),
    .busy_cnt    (busy_cnt)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd_addr
    assign rd_addr_s[g] = rd_addr[port_lo(g, AW) +: AW];
  end

  // Writes to a hard-wired r0 are dropped.
  always_comb begin
    wr_en_s = 1'b0;
    if (we && !(ZERO_R0 && (wr_addr == {AW{1'b0}}))) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Data array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_r[r] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  // Read muxes; r0 suppression takes priority over forwarding.
  always_comb begin
    rd_data = {(NRD*DATA_W){1'b0}};
    rd_busy = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      if (ZERO_R0 && (rd_addr_s[i] == {AW{1'b0}})) begin
        rd_data[port_lo(i, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[i]                            = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (we && (rd_addr_s[i] == wr_addr)) begin
        rd_data[port_lo(i, DATA_W) +: DATA_W] = wr_data;
        rd_busy[i]                            = 1'b0;
      end
`endif
      else begin
        rd_data[port_lo(i, DATA_W) +: DATA_W] = mem_r[rd_addr_s[i]];
        rd_busy[i]                            = busy_s[rd_addr_s[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;

  localparam int K_RD0  = 0;
  localparam int K_RD1  = 1;
  localparam int K_BSY0 = 2;
  localparam int K_BSY1 = 3;
  localparam int K_RDY  = 4;
  localparam int K_CNT  = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic [5:0]  busy_cnt;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_sb dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .busy_cnt    (busy_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RD0:   act = rd_data[31:0];
        K_RD1:   act = rd_data[63:32];
        K_BSY0:  act = {31'd0, rd_busy[0]};
        K_BSY1:  act = {31'd0, rd_busy[1]};
        K_RDY:   act = {31'd0, issue_ready};
        K_CNT:   act = {26'd0, busy_cnt};
        default: act = 32'hxxxxxxxx;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    we          = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    rd_addr     = 10'd0;
    we          = 1'b0;
    wr_addr     = 5'd0;
    wr_data     = 32'd0;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    cyc();
    cyc();
    reset = 1'b0;

    // Post-reset sweep of all addresses on both ports.
    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], 5'(31 - a));
      issue_addr = a[4:0];
      expect_val(K_RD0, 32'd0, "rst_rd0");
      expect_val(K_RD1, 32'd0, "rst_rd1");
      expect_val(K_BSY0, 32'd0, "rst_busy0");
      expect_val(K_BSY1, 32'd0, "rst_busy1");
      expect_val(K_RDY, 32'd1, "rst_ready");
      expect_val(K_CNT, 32'd0, "rst_cnt");
      cyc();
    end

    // r5 write, then r0 write is dropped.
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cyc();
    wr_addr = 5'd0; wr_data = 32'h00001234;
    cyc();
    idle();
    set_rd(5'd5, 5'd0);
    expect_val(K_RD0, 32'hDEADBEEF, "wr_r5");
    expect_val(K_RD1, 32'd0, "wr_r0_dropped");
    expect_val(K_CNT, 32'd0, "wr_nonbusy_cnt");
    cyc();

    // Issue r7, re-issue blocked, writeback clears.
    issue_valid = 1'b1; issue_addr = 5'd7;
    expect_val(K_RDY, 32'd1, "iss7_ready");
    cyc();
    set_rd(5'd7, 5'd7);
    expect_val(K_CNT, 32'd1, "iss7_cnt");
    expect_val(K_BSY0, 32'd1, "iss7_busy");
    expect_val(K_RDY, 32'd0, "reiss7_ready");
    cyc();
    idle();
    expect_val(K_CNT, 32'd1, "reiss7_cnt");
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
`ifdef REGFILE_BYPASS_EN
    expect_val(K_RD0, 32'h55, "wb7_fwd_data");
    expect_val(K_BSY0, 32'd0, "wb7_fwd_busy");
`else
    expect_val(K_RD0, 32'd0, "wb7_old_data");
    expect_val(K_BSY0, 32'd1, "wb7_old_busy");
`endif
    cyc();
    idle();
    expect_val(K_RD0, 32'h55, "wb7_data");
    expect_val(K_BSY0, 32'd0, "wb7_busy");
    expect_val(K_CNT, 32'd0, "wb7_cnt");
    cyc();

    // Same-cycle issue + write on a free register: net busy.
    issue_valid = 1'b1; issue_addr = 5'd9;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA;
    expect_val(K_RDY, 32'd1, "iw9_ready");
    cyc();
    idle();
    set_rd(5'd9, 5'd9);
    expect_val(K_CNT, 32'd1, "iw9_cnt");
    expect_val(K_RD0, 32'hA, "iw9_data");
    expect_val(K_BSY0, 32'd1, "iw9_busy");
    issue_valid = 1'b1; issue_addr = 5'd7;
    cyc();
    // Issue r3 while writing back busy r7: count unchanged.
    issue_addr = 5'd3;
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hB;
    expect_val(K_CNT, 32'd2, "iw3_pre_cnt");
    expect_val(K_RDY, 32'd1, "iw3_ready");
    cyc();
    idle();
    set_rd(5'd3, 5'd7);
    expect_val(K_CNT, 32'd2, "iw3_cnt");
    expect_val(K_BSY0, 32'd1, "iw3_busy3");
    expect_val(K_BSY1, 32'd0, "iw3_busy7");
    expect_val(K_RD1, 32'hB, "iw3_data7");
    cyc();

    // Issue of r0 is accepted but marks nothing.
    issue_valid = 1'b1; issue_addr = 5'd0;
    expect_val(K_RDY, 32'd1, "iss0_ready");
    cyc();
    idle();
    set_rd(5'd0, 5'd9);
    expect_val(K_CNT, 32'd2, "iss0_cnt");
    expect_val(K_BSY0, 32'd0, "iss0_busy");
    cyc();

    // Same-cycle read of the write address.
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
    set_rd(5'd5, 5'd4);
`ifdef REGFILE_BYPASS_EN
    expect_val(K_RD1, 32'h77, "byp4_data");
`else
    expect_val(K_RD1, 32'd0, "nobyp4_data");
`endif
    expect_val(K_BSY1, 32'd0, "byp4_busy");
    cyc();
    idle();
    expect_val(K_RD1, 32'h77, "wr4_data");
    cyc();

    // Issue r1, r2 (r3 already busy) then reset with a concurrent write/issue.
    issue_valid = 1'b1; issue_addr = 5'd1;
    cyc();
    issue_addr = 5'd2;
    cyc();
    idle();
    expect_val(K_CNT, 32'd4, "pre_rst_cnt");
    cyc();
    reset = 1'b1;
    we = 1'b1; wr_addr = 5'd1; wr_data = 32'hFF;
    issue_valid = 1'b1; issue_addr = 5'd6;
    cyc();
    reset = 1'b0;
    idle();
    for (int a = 1; a < 10; a++) begin
      set_rd(a[4:0], 5'(a + 1));
      issue_addr = a[4:0];
      expect_val(K_RD0, 32'd0, "mid_rst_rd0");
      expect_val(K_RD1, 32'd0, "mid_rst_rd1");
      expect_val(K_BSY0, 32'd0, "mid_rst_busy0");
      expect_val(K_BSY1, 32'd0, "mid_rst_busy1");
      expect_val(K_RDY, 32'd1, "mid_rst_ready");
      expect_val(K_CNT, 32'd0, "mid_rst_cnt");
      cyc();
    end

    cyc();
    cyc();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
